// File: rtl/cal_serial_if.sv
// cal_serial_if: start/busy/done handshake, operands and results of the bit-serial controller
interface cal_serial_if #(parameter int WIDTH = 8);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;
  modport master (output start, op, a_in, b_in, input result, carry_out, overflow, busy, done);
  modport slave  (input start, op, a_in, b_in, output result, carry_out, overflow, busy, done);
endinterface

// File: rtl/cal_serial_ctrl.sv
// cal_serial_ctrl: bit-serial AND/OR/ADD/SUB controller driving a 1-bit cal ALU slice, LSB first
module cal (
  input  logic       a,
  input  logic       b,
  input  logic       s,
  input  logic       cin,
  input  logic [1:0] clop,
  output logic       out,
  output logic       c_out
);
  logic bp;
  assign bp    = b ^ s;
  assign out   = clop == 2'b00 ? a & bp : clop == 2'b01 ? a | bp : a ^ bp ^ cin;
  assign c_out = (clop == 2'b10) & ((a & bp) | (a & cin) | (bp & cin));
endmodule

module cal_serial_ctrl #(parameter int WIDTH = 8) (
  input logic         clk,
  input logic         reset,
  cal_serial_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state, state_n;
  logic [WIDTH-1:0] a_sh, b_sh, r_sh, result;
  logic [1:0]       op_r, clop;
  logic [CW-1:0]    cnt;
  logic             cy, cmsb, carry_out, overflow;
  logic             run, last, arith, sa, sb, ss, scin, out, c_out;
  assign run   = state == RUN;
  assign last  = cnt == CW'(WIDTH - 1);
  assign arith = op_r[1];
  // slice inputs are forced to zero outside RUN so they are never unknown
  assign sa    = run & a_sh[0];
  assign sb    = run & b_sh[0];
  assign ss    = run & (op_r == 2'b11);
  assign scin  = run & cy;
  assign clop  = run ? (arith ? 2'b10 : op_r) : 2'b00;
  cal u_cal (.a(sa), .b(sb), .s(ss), .cin(scin), .clop(clop), .out(out), .c_out(c_out));
  always_comb begin
    state_n = state == IDLE ? (bus.start ? RUN : IDLE) : run ? (last ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      a_sh      <= '0;
      b_sh      <= '0;
      r_sh      <= '0;
      op_r      <= '0;
      cnt       <= '0;
      cy        <= 1'b0;
      cmsb      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.start) begin
        a_sh <= bus.a_in;
        b_sh <= bus.b_in;
        op_r <= bus.op;
        cnt  <= '0;
        cy   <= bus.op == 2'b11;
      end else if (run) begin
        a_sh <= a_sh >> 1;
        b_sh <= b_sh >> 1;
        r_sh <= {out, r_sh[WIDTH-1:1]};
        cy   <= arith & c_out;
        cnt  <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 2)) cmsb <= c_out;
        if (last) begin
          result    <= {out, r_sh[WIDTH-1:1]};
          carry_out <= arith & c_out;
          overflow  <= arith & (cmsb ^ c_out);
        end
      end
    end
  end
  assign bus.result    = result;
  assign bus.carry_out = carry_out;
  assign bus.overflow  = overflow;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE;
endmodule

// File: tb/tb_cal_serial_ctrl.sv
// tb_cal_serial_ctrl: directed and randomized checks of cal_serial_ctrl against an arithmetic model
module tb_cal_serial_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int total = 0, bad = 0, dones = 0;
  always #5 clk = ~clk;
  cal_serial_if #(.WIDTH(W)) bus ();
  cal_serial_ctrl #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0]   s;
    logic [W-1:0] d;
    s = {1'b0, a} + {1'b0, b};
    d = a - b;
    case (o)
      2'd0: return {2'b00, a & b};
      2'd1: return {2'b00, a | b};
      2'd2: return {(a[W-1] == b[W-1]) && (s[W-1] != a[W-1]), s[W], s[W-1:0]};
      default: return {(a[W-1] != b[W-1]) && (d[W-1] != a[W-1]), a >= b, d};
    endcase
  endfunction
  always @(negedge clk) begin
    if (bus.done === 1'b1) dones++;
    if (!reset) begin
      check("clop_known", {31'b0, $isunknown(dut.clop)}, 32'd0);
      if (!bus.busy || bus.done) check("clop_idle", {30'b0, dut.clop}, 32'd0);
    end
  end
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] er, input logic ec, input logic eo, input bit inject);
    int n, d0;
    @(negedge clk);
    bus.op = o; bus.a_in = a; bus.b_in = b; bus.start = 1'b1;
    d0 = dones;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a_in = W'($urandom); bus.b_in = W'($urandom); bus.op = 2'($urandom);
    check("busy_after_start", bus.busy, 1);
    check("done_early", bus.done, 0);
    n = 0;
    while (bus.done !== 1'b1 && n < 3 * W) begin
      bus.start = inject && n == 3;
      @(posedge clk); #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", n, W);
    check("result", er, er === bus.result ? er : bus.result);
    check("result_val", bus.result, er);
    check("carry_out", bus.carry_out, ec);
    check("overflow", bus.overflow, eo);
    if (inject) begin
      bus.start = 1'b1; bus.a_in = W'($urandom); bus.op = 2'($urandom);
    end
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("busy_after_done", bus.busy, 0);
    check("done_one_cycle", bus.done, 0);
    @(posedge clk); #1;
    check("start_not_queued", bus.busy, 0);
    check("result_hold", bus.result, er);
    check("done_count", dones - d0, 1);
  endtask
  initial begin
    logic [W+1:0] m;
    logic [1:0]   o;
    logic [W-1:0] a, b;
    int d0;
    bus.start = 1'b0; bus.op = 2'b00; bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_result", bus.result, 0);
    check("rst_carry", bus.carry_out, 0);
    check("rst_ovf", bus.overflow, 0);
    do_op(2'd2, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0, 1'b0);
    do_op(2'd2, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0);
    do_op(2'd2, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0);
    do_op(2'd3, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0);
    do_op(2'd3, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0, 1'b0);
    do_op(2'd0, 8'hF0, 8'h3C, 8'h30, 1'b0, 1'b0, 1'b0);
    do_op(2'd1, 8'hF0, 8'h3C, 8'hFC, 1'b0, 1'b0, 1'b0);
    do_op(2'd2, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b1);
    do_op(2'd3, 8'h34, 8'h12, 8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    bus.op = 2'd2; bus.a_in = 8'h01; bus.b_in = 8'h01; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    d0 = dones;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_result", bus.result, 0);
    check("abort_carry", bus.carry_out, 0);
    check("abort_ovf", bus.overflow, 0);
    repeat (W + 3) @(posedge clk);
    #1 check("abort_no_done", dones - d0, 0);
    do_op(2'd2, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom_range(0, 3));
      a = W'($urandom);
      b = W'($urandom);
      m = model(o, a, b);
      do_op(o, a, b, m[W-1:0], m[W], m[W+1], i % 4 == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
